// File: rtl/arith_pkg.sv
// Shared arithmetic constants: FSM state encoding and default operand width
// for the serial arithmetic blocks.
package arith_pkg;

    localparam int unsigned ARITH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

endpackage

// File: rtl/complete_adder.sv
// One-bit full adder cell shared by the ripple and serial arithmetic blocks.
module complete_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = x - y - b_in, LSB first, one bit per clock.
// Optional signed-overflow flag port ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             b_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    arith_state_e     state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-2:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;

    logic             diff;
    logic             carry;
    logic             br_next;
    logic [WIDTH-1:0] r_shift;

    // Subtraction as x0 + ~y0 + carry-in, where carry = ~borrow.
    complete_adder u_complete_adder (
        .a_i (x_q[0]),
        .b_i (~y_q[0]),
        .c_i (~br_q),
        .s_o (diff),
        .c_o (carry)
    );

    assign br_next = ~carry;
    assign r_shift = {diff, r_q};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        b_out_d = b_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    br_d    = b_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                r_d   = r_shift[WIDTH-1:1];
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = ST_DONE;
                    d_d     = r_shift;
                    b_out_d = br_next;
                    // x_q[0]/y_q[0] hold the captured operand MSBs on the last bit.
                    ovf_d   = (x_q[0] ^ y_q[0]) & (diff ^ x_q[0]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d     = d_q;
    assign b_out = b_out_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), including the
// back-to-back, ignored-start and mid-operation reset cases.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         b_in;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] d;
    logic         b_out;
    logic         busy;
    logic         done;
    logic         ovf;

    int vectors;
    int miscompares;
    int done_cnt;

    serial_subtractor #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .b_in  (b_in),
        .x     (x),
        .y     (y),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .d     (d),
        .b_out (b_out),
        .busy  (busy),
        .done  (done)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge; start is sampled on the next rising edge
    // (cycle 0), after which the inputs are scrambled to prove they were captured.
    task automatic apply(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
        @(negedge clk);
        start = 1'b1;
        x     = xv;
        y     = yv;
        b_in  = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = ~xv;
        y     = ~yv;
        b_in  = ~bv;
    endtask

    // Sample cycles first_n..W+1 after the accepted start; returns in the DONE cycle.
    task automatic expect_op(input string tag, input logic [W-1:0] exp_d, input logic exp_b,
                             input int first_n);
        for (int n = first_n; n <= W + 1; n++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, (n <= W) ? 1'b1 : 1'b0);
            chk({tag, "_done"}, done, (n == W + 1) ? 1'b1 : 1'b0);
        end
        chk({tag, "_d"}, d, exp_d);
        chk({tag, "_bout"}, b_out, exp_b);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b1;
        start = 1'b0;
        b_in  = 1'b0;
        x     = '0;
        y     = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_d", d, 4'h0);
        chk("rst_bout", b_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;

        apply(4'd9, 4'd3, 1'b0);
        expect_op("s9m3", 4'h6, 1'b0, 1);
        @(negedge clk);
        chk("s9m3_pulse", done, 1'b0);
        chk("s9m3_hold", d, 4'h6);

        apply(4'd3, 4'd9, 1'b0);
        expect_op("s3m9", 4'hA, 1'b1, 1);

        apply(4'd0, 4'd0, 1'b1);
        expect_op("s0m0b", 4'hF, 1'b1, 1);

        apply(4'd15, 4'd0, 1'b1);
        expect_op("s15m0b", 4'hE, 1'b0, 1);

        // Back-to-back: start held in the DONE cycle of a 9-3 run.
        apply(4'd9, 4'd3, 1'b0);
        expect_op("b2b_a", 4'h6, 1'b0, 1);
        start = 1'b1;
        x     = 4'd7;
        y     = 4'd7;
        b_in  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 4'd1;
        y     = 4'd2;
        expect_op("b2b_b", 4'h0, 1'b0, 1);

        // start in cycle 2 of a busy operation must be ignored.
        apply(4'd9, 4'd3, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        x     = 4'd1;
        y     = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_op("ign", 4'h6, 1'b0, 3);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("ign_extra_done", done_cnt[15:0], 16'd0);
        chk("ign_hold", d, 4'h6);

        // Reset in cycle 3 of an operation.
        apply(4'd3, 4'd9, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_d", d, 4'h0);
        chk("mrst_bout", b_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("mrst_quiet", done_cnt[15:0], 16'd0);

        apply(4'd8, 4'd1, 1'b0);
        expect_op("s8m1", 4'h7, 1'b0, 1);
`ifdef SERIAL_SUB_OVF_EN
        chk("s8m1_ovf", ovf, 1'b1);
`endif
        apply(4'd5, 4'd2, 1'b0);
        expect_op("s5m2", 4'h3, 1'b0, 1);
`ifdef SERIAL_SUB_OVF_EN
        chk("s5m2_ovf", ovf, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
